// File: rtl/spectrum_peak_find.sv
// Streaming top-2 local-maximum finder over the usable half-spectrum of one FFT frame.
// Results are published one cycle after the eop beat and held until the next frame end.
module spectrum_peak_find #(
  parameter int               FFT_N   = 1024,
  parameter int               BIN_W   = 10,
  parameter int               MAG_W   = 16,
  parameter int               DC_SKIP = 2,
  parameter logic [MAG_W-1:0] MIN_MAG = MAG_W'(64)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] data_modulus,
  input  logic             data_valid,
  input  logic             data_eop,
  output logic             peak_done,
  output logic [BIN_W-1:0] peak1_idx,
  output logic [MAG_W-1:0] peak1_mag,
  output logic [BIN_W-1:0] peak2_idx,
  output logic [MAG_W-1:0] peak2_mag,
  output logic [1:0]       peak_num,
  output logic             frame_err
);

  // Counter values (index of the current beat k) for which bin k-1 may be a candidate.
  localparam logic [BIN_W-1:0] LoCnt   = BIN_W'(DC_SKIP + 1);
  localparam logic [BIN_W-1:0] HiCnt   = BIN_W'(FFT_N / 2);
  localparam logic [BIN_W-1:0] LastCnt = BIN_W'(FFT_N - 1);

  logic [BIN_W-1:0] r_binCnt;
  logic             r_over;
  logic [MAG_W-1:0] r_m1;
  logic [MAG_W-1:0] r_m2;

  logic             r_p1Vld;
  logic [BIN_W-1:0] r_p1Idx;
  logic [MAG_W-1:0] r_p1Mag;
  logic             r_p2Vld;
  logic [BIN_W-1:0] r_p2Idx;
  logic [MAG_W-1:0] r_p2Mag;

  logic             r_peakDone;
  logic [BIN_W-1:0] r_out1Idx;
  logic [MAG_W-1:0] r_out1Mag;
  logic [BIN_W-1:0] r_out2Idx;
  logic [MAG_W-1:0] r_out2Mag;
  logic [1:0]       r_peakNum;
  logic             r_frameErr;

  logic             w_cand;
  logic [BIN_W-1:0] w_candIdx;
  logic             w_n1Vld;
  logic [BIN_W-1:0] w_n1Idx;
  logic [MAG_W-1:0] w_n1Mag;
  logic             w_n2Vld;
  logic [BIN_W-1:0] w_n2Idx;
  logic [MAG_W-1:0] w_n2Mag;
  logic             w_last;

  assign w_last = data_valid && data_eop;

  // Evaluate bin k-1 against its neighbours and fold it into the running top-2.
  always_comb begin
    w_candIdx = r_binCnt - BIN_W'(1);
    w_cand    = data_valid && (r_binCnt >= LoCnt) && (r_binCnt <= HiCnt) &&
                (r_m2 < r_m1) && (r_m1 >= data_modulus) && (r_m1 >= MIN_MAG);
    w_n1Vld = r_p1Vld;
    w_n1Idx = r_p1Idx;
    w_n1Mag = r_p1Mag;
    w_n2Vld = r_p2Vld;
    w_n2Idx = r_p2Idx;
    w_n2Mag = r_p2Mag;
    if (w_cand) begin
      if (!r_p1Vld || (r_m1 > r_p1Mag)) begin
        w_n2Vld = r_p1Vld;
        w_n2Idx = r_p1Idx;
        w_n2Mag = r_p1Mag;
        w_n1Vld = 1'b1;
        w_n1Idx = w_candIdx;
        w_n1Mag = r_m1;
      end else if (!r_p2Vld || (r_m1 > r_p2Mag)) begin
        w_n2Vld = 1'b1;
        w_n2Idx = w_candIdx;
        w_n2Mag = r_m1;
      end
    end
  end

  // Per-frame tracking state; cleared on the eop beat so the next frame can start immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binCnt <= '0;
      r_over   <= 1'b0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_p1Vld  <= 1'b0;
      r_p1Idx  <= '0;
      r_p1Mag  <= '0;
      r_p2Vld  <= 1'b0;
      r_p2Idx  <= '0;
      r_p2Mag  <= '0;
    end else if (w_last) begin
      r_binCnt <= '0;
      r_over   <= 1'b0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_p1Vld  <= 1'b0;
      r_p1Idx  <= '0;
      r_p1Mag  <= '0;
      r_p2Vld  <= 1'b0;
      r_p2Idx  <= '0;
      r_p2Mag  <= '0;
    end else if (data_valid) begin
      // The count saturates, so overlong frames are remembered separately.
      if (r_binCnt == LastCnt) begin
        r_over <= 1'b1;
      end else begin
        r_binCnt <= r_binCnt + BIN_W'(1);
      end
      r_m2    <= r_m1;
      r_m1    <= data_modulus;
      r_p1Vld <= w_n1Vld;
      r_p1Idx <= w_n1Idx;
      r_p1Mag <= w_n1Mag;
      r_p2Vld <= w_n2Vld;
      r_p2Idx <= w_n2Idx;
      r_p2Mag <= w_n2Mag;
    end
  end

  // Published results, loaded only at frame end and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peakDone <= 1'b0;
      r_out1Idx  <= '0;
      r_out1Mag  <= '0;
      r_out2Idx  <= '0;
      r_out2Mag  <= '0;
      r_peakNum  <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_peakDone <= w_last;
      if (w_last) begin
        r_out1Idx  <= w_n1Vld ? w_n1Idx : '0;
        r_out1Mag  <= w_n1Vld ? w_n1Mag : '0;
        r_out2Idx  <= w_n2Vld ? w_n2Idx : '0;
        r_out2Mag  <= w_n2Vld ? w_n2Mag : '0;
        r_peakNum  <= 2'(w_n1Vld) + 2'(w_n2Vld);
        r_frameErr <= (r_binCnt != LastCnt) || r_over;
      end
    end
  end

  assign peak_done = r_peakDone;
  assign peak1_idx = r_out1Idx;
  assign peak1_mag = r_out1Mag;
  assign peak2_idx = r_out2Idx;
  assign peak2_mag = r_out2Mag;
  assign peak_num  = r_peakNum;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_spectrum_peak_find.sv
// Scoreboard bench for spectrum_peak_find: directed frames push expected results,
// a negedge monitor pops and compares whenever peak_done is seen.
module tb_spectrum_peak_find;

  localparam int FFT_N = 16;
  localparam int BIN_W = 4;
  localparam int MAG_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [MAG_W-1:0] data_modulus = '0;
  logic             data_valid = 1'b0;
  logic             data_eop = 1'b0;
  logic             peak_done;
  logic [BIN_W-1:0] peak1_idx;
  logic [MAG_W-1:0] peak1_mag;
  logic [BIN_W-1:0] peak2_idx;
  logic [MAG_W-1:0] peak2_mag;
  logic [1:0]       peak_num;
  logic             frame_err;

  spectrum_peak_find #(
    .FFT_N(FFT_N), .BIN_W(BIN_W), .MAG_W(MAG_W), .DC_SKIP(2), .MIN_MAG(16'd10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_modulus(data_modulus), .data_valid(data_valid),
    .data_eop(data_eop), .peak_done(peak_done), .peak1_idx(peak1_idx),
    .peak1_mag(peak1_mag), .peak2_idx(peak2_idx), .peak2_mag(peak2_mag),
    .peak_num(peak_num), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx1; int mag1; int idx2; int mag2; int num; int err; int cyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  int   checks = 0;
  int   failures = 0;
  int   cycCnt = 0;
  int   frameMag[32];
  logic prevDone = 1'b0;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every peak_done must match the oldest pending expectation, on the predicted cycle.
  always @(negedge clk) begin
    if (peak_done) begin
      checkOutput("done_width", int'(prevDone), 0);
      checkOutput("sb_nonempty", int'(sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        monExp = sbQ.pop_front();
        checkOutput("done_cycle", cycCnt, monExp.cyc);
        checkOutput("peak1_idx", int'(peak1_idx), monExp.idx1);
        checkOutput("peak1_mag", int'(peak1_mag), monExp.mag1);
        checkOutput("peak2_idx", int'(peak2_idx), monExp.idx2);
        checkOutput("peak2_mag", int'(peak2_mag), monExp.mag2);
        checkOutput("peak_num", int'(peak_num), monExp.num);
        checkOutput("frame_err", int'(frame_err), monExp.err);
      end
    end
    prevDone <= peak_done;
  end

  task automatic clearFrame();
    for (int i = 0; i < 32; i++) frameMag[i] = 5;
  endtask

  // Sends frameMag[0..nBeats-1] with eop on the last beat and optional random idle gaps.
  task automatic applyStimulus(input int nBeats, input int gapMax,
                               input int i1, input int m1, input int i2, input int m2,
                               input int num, input int err);
    exp_t e;
    for (int b = 0; b < nBeats; b++) begin
      if (b > 0) begin
        repeat ($urandom_range(gapMax, 0)) begin
          @(negedge clk);
          data_valid   = 1'b0;
          data_eop     = 1'($urandom_range(1, 0));
          data_modulus = 16'($urandom_range(65535, 0));
        end
      end
      @(negedge clk);
      data_valid   = 1'b1;
      data_modulus = 16'(frameMag[b]);
      data_eop     = (b == nBeats - 1);
      if (b == nBeats - 1) begin
        e = '{i1, m1, i2, m2, num, err, cycCnt + 1};
        sbQ.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid = 1'b0;
      data_eop   = 1'b0;
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_done", int'(peak_done), 0);
    checkOutput("rst_p1_idx", int'(peak1_idx), 0);
    checkOutput("rst_p1_mag", int'(peak1_mag), 0);
    checkOutput("rst_p2_idx", int'(peak2_idx), 0);
    checkOutput("rst_p2_mag", int'(peak2_mag), 0);
    checkOutput("rst_num", int'(peak_num), 0);
    checkOutput("rst_err", int'(frame_err), 0);
  endtask

  initial begin
    int t;
    #12;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Two separated peaks, larger one later.
    clearFrame(); frameMag[3] = 100; frameMag[6] = 200;
    applyStimulus(16, 0, 6, 200, 3, 100, 2, 0);
    idle(3);

    // Equal peaks keep the lower index first; plateau 9..10 lies above the half-spectrum.
    clearFrame(); frameMag[3] = 150; frameMag[5] = 150; frameMag[9] = 50; frameMag[10] = 50;
    applyStimulus(16, 0, 3, 150, 5, 150, 2, 0);
    idle(2);

    // Flat top: only its first bin counts.
    clearFrame(); frameMag[4] = 80; frameMag[5] = 80;
    applyStimulus(16, 0, 4, 80, 0, 0, 1, 0);
    idle(2);

    // DC bins, upper-half bins and sub-threshold bins are rejected.
    clearFrame(); frameMag[0] = 1000; frameMag[1] = 900; frameMag[10] = 500;
    frameMag[4] = 20; frameMag[6] = 8;
    applyStimulus(16, 0, 4, 20, 0, 0, 1, 0);
    idle(2);

    // Gapped frame followed back-to-back by a second frame; bin 7 is the top edge.
    clearFrame(); frameMag[3] = 100; frameMag[6] = 200;
    applyStimulus(16, 3, 6, 200, 3, 100, 2, 0);
    clearFrame(); frameMag[7] = 300; frameMag[2] = 50;
    applyStimulus(16, 0, 7, 300, 2, 50, 2, 0);
    idle(2);

    // Short frame, then a short frame whose candidate is evaluated on the eop beat itself.
    clearFrame(); frameMag[4] = 60;
    applyStimulus(11, 0, 4, 60, 0, 0, 1, 1);
    applyStimulus(6, 0, 4, 60, 0, 0, 1, 1);
    clearFrame(); frameMag[3] = 100; frameMag[6] = 200;
    applyStimulus(16, 0, 6, 200, 3, 100, 2, 0);
    idle(2);

    // Overlong frame: extra beats never become candidates.
    clearFrame(); frameMag[3] = 100;
    applyStimulus(18, 0, 3, 100, 0, 0, 1, 1);
    idle(2);

    // Bin 8 is just outside the usable half and must not win.
    clearFrame(); frameMag[8] = 400; frameMag[5] = 30;
    applyStimulus(16, 0, 5, 30, 0, 0, 1, 0);
    idle(4);

    // Mid-frame reset discards the partial frame and clears the held outputs.
    clearFrame(); frameMag[3] = 100;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      data_valid   = 1'b1;
      data_eop     = 1'b0;
      data_modulus = 16'(frameMag[b]);
    end
    @(negedge clk);
    data_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    clearFrame(); frameMag[3] = 100; frameMag[6] = 200;
    applyStimulus(16, 0, 6, 200, 3, 100, 2, 0);
    idle(2);

    t = 0;
    while (sbQ.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    checkOutput("drain_timeout", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_find.md
# spectrum_peak_find

Streaming peak detector that sits directly downstream of `data_modulus`. It consumes the per-bin magnitude stream of one FFT frame (`data_modulus`/`data_valid`/`data_eop`) and tracks the two largest local maxima in the usable half-spectrum. After the last bin of each frame it publishes their bin indices and magnitudes for the frequency-identification logic. No backpressure; it keeps up with one beat per clock, including back-to-back frames.

## Interface
- `FFT_N`, 1024: FFT length; nominal beats per frame.
- `BIN_W`, 10: index width, log2(FFT_N).
- `MAG_W`, 16: magnitude width.
- `DC_SKIP`, 2: bins 0..DC_SKIP-1 are never candidates; must be ≥1.
- `MIN_MAG`, 16'd64: candidates with magnitude < MIN_MAG are discarded.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_modulus` in MAG_W: bin magnitude, unsigned.
- `data_valid` in 1: beat qualifier; gaps allowed.
- `data_eop` in 1: last beat of frame; meaningful only with `data_valid`.
- `peak_done` out 1: one-cycle pulse; results are updated.
- `peak1_idx` out BIN_W: bin of the largest peak.
- `peak1_mag` out MAG_W: magnitude of the largest peak.
- `peak2_idx` out BIN_W: bin of the second peak.
- `peak2_mag` out MAG_W: magnitude of the second peak.
- `peak_num` out 2: number of valid peaks found (0, 1 or 2).
- `frame_err` out 1: last frame did not contain exactly FFT_N beats.

## Operation
- **Bin counter.** `bin_cnt` counts valid beats. It is 0 at the first beat of a frame and resets to 0 on the edge that samples `data_eop`. It saturates at FFT_N-1. A beat count ≠ FFT_N sets `frame_err` for that frame.
- **Window.** Registers `m2` and `m1` hold the magnitudes of bins k-2 and k-1. When bin k (value `cur`) is sampled, bin k-1 is evaluated and the window shifts.
- **Local-maximum rule.** Bin k-1 is a candidate iff all of the following hold:
  - DC_SKIP ≤ k-1 ≤ FFT_N/2-1;
  - `m2 < m1` and `m1 >= cur`;
  - `m1 >= MIN_MAG`.
  - Plateau consequence: only the first bin of a flat top qualifies.
  - Bin FFT_N/2-1 is evaluated when bin FFT_N/2 arrives. The last beat of the frame is never itself a candidate.
- **Top-2 update** (same edge as the evaluation; candidate c):
  - If P1 is empty or c.mag > P1.mag: P2 ← P1, P1 ← c.
  - Else if P2 is empty or c.mag > P2.mag: P2 ← c.
  - Else: discard c.
  - Strict compares mean ties keep the lower index.
- **Frame end.** On the edge that samples `data_valid && data_eop`:
  - The final top-2 (including any candidate evaluated on that edge) is computed combinationally.
  - That result is loaded into the output registers, and `peak_done` is set.
  - `peak_num` is loaded with the count of non-empty slots.
  - Empty slots output idx 0 and mag 0.
  - Internal state (P1, P2, window, counter) is cleared to start-of-frame on that same edge, so a next-frame beat on the following cycle is handled normally.
- **Held outputs.** Output registers hold their values until the next frame end.
- **Ignored beats.** Beats with `data_valid` low are ignored entirely. Gaps do not alter results.

## Timing
- **Reset.** `rst_n` low asynchronously clears all outputs to 0 (`peak_done`, indices, magnitudes, `peak_num`, `frame_err`) and all internal state. A partially received frame is discarded. The first beat after reset release is bin 0.
- **Latency.** `peak_done` is high for exactly the one cycle following the clock edge that sampled the eop beat. All result outputs are valid in that same cycle.
- **Throughput.** One beat per clock, sustained. Frames may be back-to-back with zero idle cycles.
- **Error cases.**
  - Eop on beat < FFT_N: `frame_err`=1. Peaks are reported normally from the bins seen.
  - More than FFT_N beats before eop: beats past FFT_N-1 only feed the window and are never candidates; `frame_err`=1.
- **Widths.** Magnitude compares are unsigned MAG_W. The index is the counter value minus 1, in BIN_W bits.

## Test plan
Bench parameters: FFT_N=16, BIN_W=4, DC_SKIP=2, MIN_MAG=10. All bins not listed have magnitude 5.

1. bin3=100, bin6=200, 16 beats with eop on beat 15 → `peak_done` pulses one cycle after the eop edge; P1=(6,200), P2=(3,100), `peak_num`=2, `frame_err`=0.
2. bin3=150, bin5=150 (tie), plus plateau bins 9..10 skipped → P1=(3,150), P2=(5,150). A separate frame with bin4=bin5=80 → P1=(4,80), `peak_num`=1.
3. bin0=1000, bin1=900, bin10=500, bin4=20, bin6=8 → only bin4 qualifies: P1=(4,20), P2=(0,0), `peak_num`=1.
4. Frame 1 as in test 1 with random `data_valid` gaps, followed immediately by frame 2 (bin7=300, bin2=50) with no idle cycle → frame 1 results are identical to test 1; frame 2 gives P1=(7,300), P2=(2,50). Bin 7 is evaluated when bin 8 arrives.
5. Eop on beat 10 with bin4=60 → P1=(4,60), `frame_err`=1. The next full frame gives `frame_err`=0.
6. `rst_n` pulsed low after 7 beats of a frame containing bin3=100 → all outputs 0 immediately, no `peak_done`. A following full frame as in test 1 gives exactly the test-1 results.
